// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Start/busy/done handshake; bcd_out/overflow update only on completion.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(BIN_W + 1);
  localparam int unsigned SW = 4 * DIGITS;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [BIN_W-1:0] r_shreg;
  logic [SW-1:0]    r_scratch;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [SW-1:0]    r_bcd;
  logic             r_ovf_out;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_next_scratch;
  logic [BIN_W-1:0] w_next_shreg;
  logic             w_top;
  logic             w_last;

  always_comb begin
    w_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      else
        w_adj[4*d +: 4] = r_scratch[4*d +: 4];
    end
    // The bit leaving the top digit is lost, so it marks an out-of-range value.
    w_top          = w_adj[SW-1];
    w_next_scratch = {w_adj[SW-2:0], r_shreg[BIN_W-1]};
    w_next_shreg   = r_shreg << 1;
    w_last         = (r_cnt == CW'(BIN_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shreg   <= bin_in;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        default: begin
          r_scratch <= w_next_scratch;
          r_shreg   <= w_next_shreg;
          r_ovf     <= r_ovf | w_top;
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd     <= w_next_scratch;
            r_ovf_out <= r_ovf | w_top;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign overflow = r_ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake cases plus a full
// sweep and random values checked against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int n_assert = 0;
  int n_fail   = 0;
  int lat, cnt_busy, cnt_done, v, w;
  logic [11:0] res [256];

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a)
  );

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b)
  );

  // Decimal digits of v by repeated division, four digits wide.
  function automatic logic [15:0] ref_bcd(input int val);
    logic [15:0] r;
    int t;
    r = '0;
    t = val;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Digit-serial decimal addition, as a BCD adder chain would perform it.
  function automatic logic [15:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [15:0] r;
    int s, c;
    r = '0;
    c = 0;
    for (int i = 0; i < 3; i++) begin
      s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (s > 9) begin s = s - 10; c = 1; end else c = 0;
      r[4*i +: 4] = 4'(s);
    end
    r[15:12] = 4'(c);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick_a(input logic [7:0] val);
    start_a = 1'b1;
    bin_a   = val;
  endtask

  // Counts negedges until done; scrambles bin_in after acceptance.
  task automatic wait_a(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
      start_a = 1'b0;
      bin_a   = 8'($urandom);
    end while (!done_a && l < 30);
  endtask

  task automatic conv_a(input int val, input string tag);
    int l;
    kick_a(8'(val));
    wait_a(l);
    chk({tag, "_lat"}, l, 9);
    chk({tag, "_bcd"}, bcd_a, ref_bcd(val));
    chk({tag, "_ovf"}, ovf_a, 0);
    @(negedge clk);
    chk({tag, "_done1"}, done_a, 0);
  endtask

  task automatic conv_b(input int val, input string tag);
    int l;
    start_b = 1'b1;
    bin_b   = 8'(val);
    l = 0;
    do begin
      @(negedge clk);
      l++;
      start_b = 1'b0;
    end while (!done_b && l < 30);
    chk({tag, "_lat"}, l, 9);
    chk({tag, "_ovf"}, ovf_b, (val > 99) ? 1 : 0);
    if (val <= 99) chk({tag, "_bcd"}, bcd_b, ref_bcd(val));
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bcd",  bcd_a, 0);
    chk("rst_ovf",  ovf_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1/T2
    conv_a(0,   "t1_0");
    conv_a(255, "t2_255");
    conv_a(99,  "t2_99");
    conv_a(10,  "t2_10");

    // T3: start while busy is ignored
    kick_a(8'd37);
    cnt_busy = 0; cnt_done = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start_a = (k == 3) ? 1'b1 : 1'b0;
      bin_a   = (k == 3) ? 8'd200 : 8'd37;
      if (busy_a) cnt_busy++;
      if (done_a) cnt_done++;
    end
    start_a = 1'b0;
    chk("t3_busy_cycles", cnt_busy, 8);
    chk("t3_done_count",  cnt_done, 1);
    chk("t3_bcd", bcd_a, 12'h037);

    // T4: back-to-back, new start in the done cycle
    kick_a(8'd45);
    wait_a(lat);
    chk("t4a_lat", lat, 9);
    chk("t4a_bcd", bcd_a, 12'h045);
    kick_a(8'd128);
    @(negedge clk);
    start_a = 1'b0;
    chk("t4_busy_nogap", busy_a, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_hold", bcd_a, 12'h045);
    wait_a(lat);
    chk("t4b_lat", lat, 6);
    chk("t4b_bcd", bcd_a, 12'h128);

    // T5: async reset mid-conversion
    @(negedge clk);
    kick_a(8'd77);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    chk("t5_bcd",  bcd_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_a) cnt_done++;
    end
    chk("t5_no_done", cnt_done, 0);
    conv_a(77, "t5_77");

    // T6: two-digit instance overflow behaviour
    conv_b(200, "t6_200");
    conv_b(99,  "t6_99");
    chk("t6_99_hex", bcd_b, 8'h99);
    conv_b(100, "t6_100");
    for (int k = 0; k < 12; k++) conv_b(int'($urandom_range(0, 255)), "t6_rnd");

    // Full sweep, results kept for the adder pairing
    for (int i = 0; i < 256; i++) begin
      kick_a(8'(i));
      wait_a(lat);
      chk("sweep_lat", lat, 9);
      chk("sweep_bcd", bcd_a, ref_bcd(i));
      chk("sweep_ovf", ovf_a, 0);
      res[i] = bcd_a;
    end

    for (int k = 0; k < 20; k++) begin
      v = int'($urandom_range(0, 255));
      w = int'($urandom_range(0, 255));
      chk("pair_sum", bcd_add(res[v], res[w]), ref_bcd(v + w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
